// File: rtl/filter_sp_controller_pkg.sv
// Shared widths, state encoding and config validation for the filter scratchpad sequencer.
package filter_sp_controller_pkg;

  localparam int NUM_REG    = 12;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int WIN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // A job is runnable only with 1..NUM_REG weights and at least one window.
  function automatic logic cfg_ok(input logic [ADDR_WIDTH-1:0] len,
                                  input logic [WIN_WIDTH-1:0]  nwin);
    return (len != '0) && (len <= ADDR_WIDTH'(NUM_REG)) && (nwin != '0);
  endfunction

endpackage

// File: rtl/filter_sp_controller_if.sv
// Weight stream in, scratchpad port, and weight stream out to the MAC.
interface filter_sp_controller_if;
  import filter_sp_controller_pkg::*;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  sp_wen;
  logic [ADDR_WIDTH-1:0] sp_waddr;
  logic [DATA_WIDTH-1:0] sp_din;
  logic [ADDR_WIDTH-1:0] sp_raddr;
  logic [DATA_WIDTH-1:0] sp_dout;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    input  in_valid, in_data, sp_dout, out_ready,
    output in_ready, sp_wen, sp_waddr, sp_din, sp_raddr, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, sp_dout, out_ready,
    input  in_ready, sp_wen, sp_waddr, sp_din, sp_raddr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/filter_sp_controller_mod_counter.sv
// Up-counter with clear, enable and a programmable terminal value; wraps to 0 on an enabled tc.
module filter_sp_controller_mod_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == tc_val_i);
  assign cnt_o = cnt_q;

  // Clear wins over enable; an enabled count at terminal value rolls back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + ONE;
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/filter_sp_controller.sv
// Filter scratchpad sequencer: loads filt_len weights, then replays them num_windows times.
//   state      | meaning
//   ST_IDLE    | waiting for start; validates and latches job config
//   ST_LOAD    | accepting weights, writing scratchpad addr 0..len-1
//   ST_COMPUTE | replaying addr 0..len-1 to the MAC once per window
//   ST_DONE    | one-cycle completion pulse
module filter_sp_controller
  import filter_sp_controller_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] filt_len_i,
  input  logic [WIN_WIDTH-1:0]  num_windows_i,
  output logic                  cfg_err_o,
  output logic                  busy_o,
  output logic                  done_o,
  filter_sp_controller_if.master sp_if
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [WIN_WIDTH-1:0]  W_ONE = WIN_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [WIN_WIDTH-1:0]  nwin_q;
  logic                  cfg_err_q;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic [WIN_WIDTH-1:0]  win;
  logic                  wcnt_tc, rcnt_tc, win_tc;
  logic                  hs_in, hs_out;

  assign hs_in  = (state_q == ST_LOAD)    && sp_if.in_valid;
  assign hs_out = (state_q == ST_COMPUTE) && sp_if.out_ready;

  filter_sp_controller_mod_counter #(.W(ADDR_WIDTH)) u_wcnt (
    .clk_i, .rst_ni, .clr_i(state_q != ST_LOAD), .en_i(hs_in),
    .tc_val_i(len_q - A_ONE), .cnt_o(wcnt), .tc_o(wcnt_tc)
  );

  filter_sp_controller_mod_counter #(.W(ADDR_WIDTH)) u_rcnt (
    .clk_i, .rst_ni, .clr_i(state_q != ST_COMPUTE), .en_i(hs_out),
    .tc_val_i(len_q - A_ONE), .cnt_o(rcnt), .tc_o(rcnt_tc)
  );

  filter_sp_controller_mod_counter #(.W(WIN_WIDTH)) u_win (
    .clk_i, .rst_ni, .clr_i(state_q != ST_COMPUTE), .en_i(hs_out && rcnt_tc),
    .tc_val_i(nwin_q - W_ONE), .cnt_o(win), .tc_o(win_tc)
  );

  // Job config is only sampled in IDLE; a rejected start leaves the old config in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q     <= '0;
      nwin_q    <= '0;
      cfg_err_q <= 1'b0;
    end else if (state_q == ST_IDLE && start_i) begin
      if (cfg_ok(filt_len_i, num_windows_i)) begin
        len_q     <= filt_len_i;
        nwin_q    <= num_windows_i;
        cfg_err_q <= 1'b0;
      end else begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i && cfg_ok(filt_len_i, num_windows_i)) state_d = ST_LOAD;
      ST_LOAD:    if (hs_in && wcnt_tc) state_d = ST_COMPUTE;
      ST_COMPUTE: if (hs_out && rcnt_tc && win_tc) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; data paths are gated so idle/reset presents all zeros.
  always_comb begin
    sp_if.in_ready  = 1'b0;
    sp_if.sp_wen    = 1'b0;
    sp_if.sp_waddr  = '0;
    sp_if.sp_din    = '0;
    sp_if.sp_raddr  = '0;
    sp_if.out_valid = 1'b0;
    sp_if.out_data  = '0;
    sp_if.out_last  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        sp_if.in_ready = 1'b1;
        sp_if.sp_wen   = sp_if.in_valid;
        sp_if.sp_waddr = wcnt;
        sp_if.sp_din   = sp_if.in_data;
      end
      ST_COMPUTE: begin
        sp_if.out_valid = 1'b1;
        sp_if.sp_raddr  = rcnt;
        sp_if.out_data  = sp_if.sp_dout;
        sp_if.out_last  = rcnt_tc;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_filter_sp_controller.sv
// Scoreboard bench: jobs push expected writes/outputs, a negedge monitor pops and compares.
module tb_filter_sp_controller;
  import filter_sp_controller_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] filt_len = '0;
  logic [WIN_WIDTH-1:0]  num_windows = '0;
  logic                  cfg_err, busy, done;

  filter_sp_controller_if ifc();

  filter_sp_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .filt_len_i(filt_len),
    .num_windows_i(num_windows), .cfg_err_o(cfg_err), .busy_o(busy), .done_o(done),
    .sp_if(ifc.master)
  );

  always #5 clk = ~clk;

  // Scratchpad model: sync write, combinational read.
  logic [DATA_WIDTH-1:0] mem [16];
  always @(posedge clk) if (ifc.sp_wen) mem[ifc.sp_waddr] <= ifc.sp_din;
  assign ifc.sp_dout = mem[ifc.sp_raddr];

  // out_ready: 0 = always ready, 1 = random, 2 = stalled.
  int rdy_mode = 0;
  always begin
    @(posedge clk);
    #1;
    ifc.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  typedef struct {logic [ADDR_WIDTH-1:0] a; logic [DATA_WIDTH-1:0] d; bit last;} wr_t;
  typedef struct {logic [DATA_WIDTH-1:0] d; bit last; bit fin;} rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit                    done_due = 0, ov_due = 0, hold_v = 0;
  logic [ADDR_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_d;

  always @(negedge clk) begin : monitor
    wr_t e;
    rd_t r;
    if (rst_n) begin
      if (done_due) begin
        check("done_pulse", done, 1);
        done_due = 0;
      end else if (done) check("done_unexpected", done, 0);
      if (ov_due) begin
        check("first_out_latency", ifc.out_valid, 1);
        ov_due = 0;
      end
      if (hold_v && ifc.out_valid) begin
        check("stall_raddr", ifc.sp_raddr, hold_a);
        check("stall_data", ifc.out_data, hold_d);
      end
      hold_v = ifc.out_valid && !ifc.out_ready;
      hold_a = ifc.sp_raddr;
      hold_d = ifc.out_data;
      if (ifc.sp_wen) begin
        check("wen_with_out_valid", ifc.out_valid, 0);
        if (wq.size() == 0) check("unexpected_write", ifc.sp_wen, 0);
        else begin
          e = wq.pop_front();
          check("wr_addr", ifc.sp_waddr, e.a);
          check("wr_data", ifc.sp_din, e.d);
          if (e.last) ov_due = 1;
        end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (rq.size() == 0) check("unexpected_out", ifc.out_valid, 0);
        else begin
          r = rq.pop_front();
          check("out_data", ifc.out_data, r.d);
          check("out_last", ifc.out_last, r.last);
          if (r.fin) done_due = 1;
        end
      end
    end
  end

  task automatic run_job(input int len, input int nw, input bit vtoggle, input bit directed,
                         input bit stall, input bit poke, input int abort_after);
    logic [DATA_WIDTH-1:0] w[$];
    int idx, guard;
    bit hs;
    for (int i = 0; i < len; i++) begin
      w.push_back(directed ? DATA_WIDTH'(5 + i) : DATA_WIDTH'($urandom_range(0, 16'hFFFF)));
      wq.push_back('{ADDR_WIDTH'(i), w[i], i == len - 1});
    end
    for (int k = 0; k < nw; k++)
      for (int i = 0; i < len; i++)
        rq.push_back('{w[i], i == len - 1, (k == nw - 1) && (i == len - 1)});

    @(posedge clk); #1;
    start = 1'b1;
    filt_len = ADDR_WIDTH'(len);
    num_windows = WIN_WIDTH'(nw);
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0;
    guard = 0;
    while (idx < len && guard < 500) begin
      ifc.in_valid = vtoggle ? (guard[0] == 1'b0) : 1'b1;
      ifc.in_data  = w[idx];
      @(negedge clk);
      if (guard == 0) begin
        check("busy_after_start", busy, 1);
        check("cfg_err_cleared", cfg_err, 0);
      end
      hs = ifc.in_valid && ifc.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
      if (abort_after != 0 && idx == abort_after) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", ifc.in_ready, 0);
        check("rst_sp_wen", ifc.sp_wen, 0);
        check("rst_sp_din", ifc.sp_din, 0);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        wq.delete();
        rq.delete();
        ifc.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        return;
      end
    end
    ifc.in_valid = 1'b0;
    if (idx < len) check("load_timeout", idx, len);

    if (stall) begin
      repeat (2) @(negedge clk);
      rdy_mode = 2;
      repeat (5) @(posedge clk);
      rdy_mode = 0;
    end
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1;
      filt_len = '0;
      num_windows = '0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("poke_cfg_err", cfg_err, 0);
      check("poke_busy", busy, 1);
    end

    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 3000);
    check("done_seen", done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("outputs_drained", rq.size(), 0);
  endtask

  task automatic bad_start(input int len, input int nw);
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    filt_len = ADDR_WIDTH'(len);
    num_windows = WIN_WIDTH'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("bad_cfg_err", cfg_err, 1);
    check("bad_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_cfg_err", cfg_err, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", ifc.in_ready, 0);
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_sp_raddr", ifc.sp_raddr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_job(3, 2, 0, 1, 0, 0, 0);
    run_job(12, 1, 1, 0, 0, 0, 0);
    run_job(8, 2, 0, 0, 1, 0, 0);
    bad_start(0, 1);
    bad_start(13, 1);
    bad_start(3, 0);
    run_job(4, 3, 0, 0, 0, 0, 0);
    run_job(5, 3, 0, 0, 0, 1, 0);
    run_job(6, 2, 0, 0, 0, 0, 2);
    run_job(3, 2, 0, 1, 0, 0, 0);
    rdy_mode = 1;
    for (int k = 0; k < 6; k++)
      run_job($urandom_range(1, NUM_REG), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
